// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM states and sizing helper for the data memory LSU
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word-index width; a two-word array still needs one index bit.
  function automatic int index_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane merge and load extract/extend for one 32-bit word
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        load_unsigned,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Halves ignore offset[0] and words ignore the whole offset, so the
  // low address bits are effectively forced aligned.
  assign byte_shift = {offset, 3'b000};
  assign half_shift = {offset[1], 4'b0000};
  assign byte_val   = old_word[byte_shift +: 8];
  assign half_val   = old_word[half_shift +: 16];

  always_comb begin
    merged_word = old_word;
    load_data   = '0;
    case (size)
      SIZE_BYTE: begin
        merged_word[byte_shift +: 8] = store_data[7:0];
        load_data = {{24{~load_unsigned & byte_val[7]}}, byte_val};
      end
      SIZE_HALF: begin
        merged_word[half_shift +: 16] = store_data[15:0];
        load_data = {{16{~load_unsigned & half_val[15]}}, half_val};
      end
      default: begin
        merged_word = store_data;
        load_data   = old_word;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - handshaked byte/half/word data memory with wait states
// Optional misalignment checking is compiled in with DMEM_MISALIGN_CHECK_EN.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        misaligned
);

  localparam int AW = index_width(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 2);

  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [CW-1:0] cnt;

  logic          lat_write;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_data;

  logic          acc_write;
  logic [1:0]    acc_size;
  logic          acc_unsigned;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_data;
  logic [AW-1:0] acc_idx;
  logic          acc_misaligned;
  logic          enter_resp;
  logic [31:0]   merged_word;
  logic [31:0]   load_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^address[31:AW+2];

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE) && !reset;

  // With zero wait states the access happens on the accepting edge, before
  // the latches hold the request, so the live request fields are used then.
  always_comb begin
    acc_write    = lat_write;
    acc_size     = lat_size;
    acc_unsigned = lat_unsigned;
    acc_addr     = lat_addr;
    acc_data     = lat_data;
    if (state == IDLE) begin
      acc_write    = req_write;
      acc_size     = req_size;
      acc_unsigned = req_unsigned;
      acc_addr     = address[AW+1:0];
      acc_data     = write_data;
    end
  end

  assign acc_idx    = acc_addr[AW+1:2];
  assign enter_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == CW'(1)));

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    acc_misaligned = 1'b0;
    case (acc_size)
      SIZE_BYTE: acc_misaligned = 1'b0;
      SIZE_HALF: acc_misaligned = acc_addr[0];
      default:   acc_misaligned = |acc_addr[1:0];
    endcase
  end
`else
  assign acc_misaligned = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .old_word      (mem[acc_idx]),
    .store_data    (acc_data),
    .size          (acc_size),
    .offset        (acc_addr[1:0]),
    .load_unsigned (acc_unsigned),
    .merged_word   (merged_word),
    .load_data     (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      read_data  <= '0;
      misaligned <= 1'b0;
    end else begin
      resp_valid <= enter_resp;
      if (enter_resp) begin
        if (acc_write && !acc_misaligned) begin
          mem[acc_idx] <= merged_word;
        end
        read_data  <= (acc_write || acc_misaligned) ? 32'd0 : load_data;
        misaligned <= acc_misaligned;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= address[AW+1:0];
            lat_data     <= write_data;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb/tb_data_memory_lsu.sv - randomized and directed checks of data_memory_lsu against a byte-array model
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        busy;
  logic        misaligned;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] model_mem [1024];

  always #5 clk = ~clk;

  data_memory_lsu #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .address      (address),
    .write_data   (write_data),
    .resp_valid   (resp_valid),
    .read_data    (read_data),
    .busy         (busy),
    .misaligned   (misaligned)
  );

  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  // First byte touched: the memory is 1024 bytes, halves/words are forced aligned.
  function automatic int base_byte(input logic [1:0] sz, input logic [31:0] a);
    int word_base;
    word_base = int'({22'd0, a[9:2], 2'b00});
    if (sz == 2'b00) return word_base + int'(a[1:0]);
    if (sz == 2'b01) return word_base + (a[1] ? 2 : 0);
    return word_base;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
  endfunction

  function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b;
    if (model_misaligned(sz, a)) return;
    b = base_byte(sz, a);
    for (int i = 0; i < nbytes(sz); i++) model_mem[b + i] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    logic [31:0] v;
    int b, n;
    if (model_misaligned(sz, a)) return 32'd0;
    v = 32'd0;
    b = base_byte(sz, a);
    n = nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[b + i];
    if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // Presents one request from idle, then waits (bounded) for its response.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic mis, output int lat);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    address      = a;
    write_data   = d;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 20);
    rd  = read_data;
    mis = misaligned;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    address   = 32'd0; write_data = 32'd0;
    model_clear();
    repeat (2) @(negedge clk);
    vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (resp_valid !== 1'b0 || read_data !== 32'd0 || misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got rv=%b rd=%h mis=%b want 0/0/0", resp_valid, read_data, misaligned);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_latency();
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; address = 32'h40;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      vectors++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
        errors++; $display("FAIL lat_busy cycle %0d got busy=%b ready=%b want 1/0", c, busy, req_ready);
      end
      vectors++; if (resp_valid !== (c == 3)) begin
        errors++; $display("FAIL lat_resp cycle %0d got %b want %b", c, resp_valid, (c == 3));
      end
      if (c == 3) begin
        vectors++; if (read_data !== 32'd0) begin errors++; $display("FAIL lat_data got %h want 0", read_data); end
      end
      @(negedge clk);
    end
    vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL lat_after got rv=%b busy=%b ready=%b want 0/0/1", resp_valid, busy, req_ready);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic mis; int lat;
    access(1, 2'b10, 0, 32'h10, 32'h1122_3344, rd, mis, lat); model_store(2'b10, 32'h10, 32'h1122_3344);
    access(1, 2'b00, 0, 32'h11, 32'h0000_00AA, rd, mis, lat); model_store(2'b00, 32'h11, 32'h0000_00AA);
    vectors++; if (rd !== 32'd0 || lat != 3) begin errors++; $display("FAIL sb_resp got rd=%h lat=%0d want 0/3", rd, lat); end
    access(0, 2'b10, 0, 32'h10, 32'h0, rd, mis, lat);
    vectors++; if (rd !== 32'h1122_AA44) begin errors++; $display("FAIL lw_merge got %h want 1122aa44", rd); end
    access(1, 2'b01, 0, 32'h22, 32'h0000_8001, rd, mis, lat); model_store(2'b01, 32'h22, 32'h0000_8001);
    access(0, 2'b01, 0, 32'h22, 32'h0, rd, mis, lat);
    vectors++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got %h want ffff8001", rd); end
    access(0, 2'b01, 1, 32'h22, 32'h0, rd, mis, lat);
    vectors++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu got %h want 00008001", rd); end
    access(0, 2'b00, 0, 32'h23, 32'h0, rd, mis, lat);
    vectors++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got %h want ffffff80", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp_rd; logic mis, w, u, exp_mis; logic [1:0] sz; int lat;
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = $urandom;
      a[9:4] = 6'($urandom_range(0, 3));
      d  = $urandom;
      exp_rd  = w ? 32'd0 : model_load(sz, u, a);
      exp_mis = model_misaligned(sz, a);
      access(w, sz, u, a, d, rd, mis, lat);
      if (w) model_store(sz, a, d);
      vectors++; if (lat != 3) begin errors++; $display("FAIL rand_lat #%0d got %0d want 3", n, lat); end
      vectors++; if (rd !== exp_rd || mis !== exp_mis) begin
        errors++; $display("FAIL rand_data #%0d w=%b sz=%0d u=%b a=%h got %h/%b want %h/%b", n, w, sz, u, a, rd, mis, exp_rd, exp_mis);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepted, first, resp_t[$], ready_t[$], ready_between;
    logic [31:0] exp_rd;
    exp_rd = model_load(2'b10, 1'b0, 32'h10);
    accepted = 0; first = -1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; address = 32'h10;
    for (int t = 0; t < 24; t++) begin
      if (accepted == 3) req_valid = 1'b0;
      if (resp_valid) begin
        resp_t.push_back(t);
        vectors++; if (read_data !== exp_rd) begin errors++; $display("FAIL b2b_data t=%0d got %h want %h", t, read_data, exp_rd); end
      end
      if (req_ready) ready_t.push_back(t);
      if (req_valid && req_ready) begin
        accepted++;
        if (first < 0) first = t;
      end
      @(negedge clk);
    end
    vectors++; if (resp_t.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", resp_t.size()); end
    else begin
      vectors++; if (resp_t[0] - first != 3 || resp_t[1] - resp_t[0] != 4 || resp_t[2] - resp_t[1] != 4) begin
        errors++; $display("FAIL b2b_spacing got %0d,%0d,%0d from %0d want +3,+4,+4", resp_t[0], resp_t[1], resp_t[2], first);
      end
      ready_between = 0;
      foreach (ready_t[i]) if (ready_t[i] > first && ready_t[i] <= resp_t[2]) ready_between++;
      vectors++; if (ready_between != 2) begin errors++; $display("FAIL b2b_ready got %0d ready cycles want 2", ready_between); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic mis, seen; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; address = 32'h8; write_data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got busy=%b ready=%b want 0/0", busy, req_ready);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= resp_valid;
      @(negedge clk);
    end
    vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_resp got pulse want none"); end
    access(0, 2'b10, 0, 32'h8, 32'h0, rd, mis, lat);
    vectors++; if (rd !== 32'd0 || lat != 3) begin errors++; $display("FAIL midreset_lw got %h lat=%0d want 0/3", rd, lat); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, exp_rd; logic mis; int lat;
    access(1, 2'b10, 0, 32'h400, 32'h5, rd, mis, lat); model_store(2'b10, 32'h400, 32'h5);
    access(0, 2'b10, 0, 32'h0, 32'h0, rd, mis, lat);
    vectors++; if (rd !== 32'h5) begin errors++; $display("FAIL wrap got %h want 5", rd); end
    access(1, 2'b10, 0, 32'h4, 32'hCAFE_F00D, rd, mis, lat); model_store(2'b10, 32'h4, 32'hCAFE_F00D);
    exp_rd = model_load(2'b10, 1'b0, 32'h6);
    access(0, 2'b10, 0, 32'h6, 32'h0, rd, mis, lat);
    vectors++; if (rd !== exp_rd || mis !== model_misaligned(2'b10, 32'h6)) begin
      errors++; $display("FAIL lw_0x6 got %h/%b want %h/%b", rd, mis, exp_rd, model_misaligned(2'b10, 32'h6));
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    vectors++; if (rd !== 32'd0 || mis !== 1'b1) begin errors++; $display("FAIL misalign got %h/%b want 0/1", rd, mis); end
`else
    vectors++; if (rd !== 32'hCAFE_F00D || mis !== 1'b0) begin errors++; $display("FAIL forced_align got %h/%b want cafef00d/0", rd, mis); end
`endif
  endtask

  initial begin
    test_reset();
    test_latency();
    test_lanes();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
Parametrised data memory for the pipelined core, replacing the fixed 256-word, single-cycle, word-only array.
- Adds byte, halfword and word loads and stores, with sign or zero extension on loads.
- Adds a valid/ready request handshake and a configurable number of wait states, so the MEM stage can stall on slow memory.
- Sits in the MEM stage; the hazard unit stalls the pipeline while busy is high.

Parameters:
DEPTH, 256, number of 32-bit words; must be a power of two, minimum 2.
WAIT_CYCLES, 2, extra stall cycles per access; 0 gives the minimum latency.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present; requester holds all req_* fields until accepted
req_ready  output  1  high only in IDLE
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
address  input  32  byte address
write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle pulse; the access has completed
read_data  output  32  extended load result; 0 for stores; held between responses
busy  output  1  high whenever state is not IDLE
misaligned  output  1  valid with resp_valid; constant 0 unless the optional feature is compiled in

Behaviour:
- Word index = address[$clog2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid: latch req_write, req_size, req_unsigned, address, write_data. Go to WAIT with cnt=WAIT_CYCLES, or straight to RESP if WAIT_CYCLES=0.
  - WAIT: cnt decrements each cycle; on the edge where cnt==1, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle; next state is IDLE.
- The array access happens on the edge that enters RESP and uses the latched fields. A store commits on that edge; load data is captured into read_data on the same edge.
- Timing: a request accepted at the end of cycle 0 produces resp_valid in cycle WAIT_CYCLES+1.
  - The earliest next acceptance is in cycle WAIT_CYCLES+2.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- req_valid is ignored in WAIT and RESP; no queueing.
- Store lanes:
  - Byte: writes lane address[1:0].
  - Half: writes lanes {address[1],0} and {address[1],1}.
  - Word: writes all four lanes.
  - Unwritten bytes are preserved, either by read-modify-write on the same edge or by byte enables.
- Load extract: selects the same lane(s) and extends to 32 bits per req_unsigned; word loads ignore req_unsigned.
- A load from a word stored in an earlier transaction returns the updated value; there is no forwarding inside a transaction.
- Reset, evaluated at the rising edge with priority over all other activity:
  - All array words cleared to 0.
  - State returns to IDLE and cnt to 0.
  - resp_valid, read_data and misaligned cleared to 0.
  - A pending request is dropped: no write, no response.
- During a reset cycle: req_ready=0 and busy=0.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined:
  - A half access with address[0]=1, or a word access with address[1:0]!=0, is misaligned.
  - A misaligned access performs no write and returns read_data=0, with misaligned=1 during its resp_valid cycle.
  - Timing is unchanged.
- Undefined:
  - Low address bits are forced aligned: address[0] is ignored for halves, address[1:0] for words.
  - misaligned is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - the state enum IDLE/WAIT/RESP;
  - a function computing the word-index width from DEPTH.
- One combinational sub-module, dmem_lane_align, provides store lane merge (old word, data, size, offset -> new word) and load extract/extend.
- The FSM, counter and array stay in the top module.

Test Plan:
1. Reset, then load word at 0x40 with WAIT_CYCLES=2 -> resp_valid in cycle 3 after acceptance, read_data=0; busy high in cycles 1-3 after acceptance.
2. SW 0x11223344 @0x10; SB 0xAA @0x11; LW @0x10 -> 0x1122AA44.
3. SH 0x8001 @0x22; LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001; LB @0x23 -> 0xFFFFFF80.
4. Hold req_valid continuously for 3 loads -> exactly 3 resp_valid pulses spaced 4 cycles apart; req_ready low between them.
5. Assert reset in the WAIT cycle of SW 0xDEADBEEF @0x8 -> no resp_valid; a later LW @0x8 returns 0.
6. DEPTH=256: SW 0x5 @0x400, then LW @0x0 -> 0x5 (wrap). With DMEM_MISALIGN_CHECK_EN, LW @0x6 -> misaligned=1, read_data=0.
